// File: rtl/rans_pkg.sv
// rANS decoder shared types and derived constants.
package rans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    LOOKUP,
    EMIT,
    RENORM,
    FINISH
  } state_e;

  localparam int FC_W = 16;

  typedef struct packed {
    logic [FC_W-1:0] freq;
    logic [FC_W-1:0] cum;
  } fc_t;

  function automatic longint unsigned lower_bound(int sw, int bw);
    return 64'(1) << (sw - bw);
  endfunction

  function automatic int init_bytes(int sw, int bw);
    return sw / bw;
  endfunction

endpackage

// File: rtl/rans_slot_ram.sv
// Single-clock RAM: one write port, one registered read port.
module rans_slot_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rans_decoder.sv
// rANS entropy decoder: consumes the encoder stream LIFO, emits
// symbols in original order.
module rans_decoder
  import rans_pkg::*;
#(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int STATE_WIDTH  = 24,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0] symb_i,
  input  logic [RESOLUTION-1:0]   freq_i,
  input  logic [RESOLUTION-1:0]   cum_freq_i,
  input  logic                    start_i,
  input  logic [COUNT_WIDTH-1:0]  count_i,
  input  logic                    byte_valid_i,
  input  logic [SYMBOL_WIDTH-1:0] byte_i,
  output logic                    byte_ready_o,
  output logic                    symb_valid_o,
  output logic [SYMBOL_WIDTH-1:0] symb_o,
  input  logic                    symb_ready_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam logic [STATE_WIDTH-1:0] LOWER_BOUND =
    STATE_WIDTH'(lower_bound(STATE_WIDTH, SYMBOL_WIDTH));
  localparam int INIT_BYTES = init_bytes(STATE_WIDTH, SYMBOL_WIDTH);
  localparam int LD_W = $clog2(INIT_BYTES + 1);

  state_e state_q, state_d;

  logic [STATE_WIDTH-1:0]  x_q, x_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LD_W-1:0]         ld_q, ld_d;
  logic                    zero_q, zero_d;
  logic [SYMBOL_WIDTH-1:0] fsym_q, fsym_d;
  logic [RESOLUTION-1:0]   faddr_q, faddr_d;
  logic [RESOLUTION-1:0]   fleft_q, fleft_d;

  logic [SYMBOL_WIDTH-1:0]   slot_rd;
  logic [2*RESOLUTION-1:0]   fc_rdata;
  fc_t                       fc_rd;
  logic [STATE_WIDTH-1:0]    x_shift;
  logic [STATE_WIDTH-1:0]    x_dec;
  logic                      below;
  logic                      slot_we;
  logic                      fc_we;

  assign fc_rd.freq = FC_W'(fc_rdata[2*RESOLUTION-1:RESOLUTION]);
  assign fc_rd.cum  = FC_W'(fc_rdata[RESOLUTION-1:0]);

  assign x_shift = {x_q[STATE_WIDTH-SYMBOL_WIDTH-1:0], byte_i};
  assign x_dec   = STATE_WIDTH'(fc_rd.freq) * (x_q >> RESOLUTION)
                 + STATE_WIDTH'(x_q[RESOLUTION-1:0])
                 - STATE_WIDTH'(fc_rd.cum);
  assign below   = x_q < LOWER_BOUND;
  assign slot_we = (state_q == FILL) && (fleft_q != '0);
  assign fc_we   = (state_q == IDLE) && freq_wr_i;

  // Slot read is addressed with next x so LOOKUP only needs the freq/cum read.
  rans_slot_ram #(
    .ADDR_W(RESOLUTION),
    .DATA_W(SYMBOL_WIDTH)
  ) u_slot_ram (
    .clk_i  (clk_i),
    .we_i   (slot_we),
    .waddr_i(faddr_q),
    .wdata_i(fsym_q),
    .raddr_i(x_d[RESOLUTION-1:0]),
    .rdata_o(slot_rd)
  );

  rans_slot_ram #(
    .ADDR_W(SYMBOL_WIDTH),
    .DATA_W(2*RESOLUTION)
  ) u_fc_ram (
    .clk_i  (clk_i),
    .we_i   (fc_we),
    .waddr_i(symb_i),
    .wdata_i({freq_i, cum_freq_i}),
    .raddr_i(slot_rd),
    .rdata_o(fc_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (freq_wr_i)            state_d = FILL;
        else if (start_i) begin
          if (count_i == '0)      state_d = FINISH;
          else                    state_d = LOAD;
        end
      end
      FILL:
        if (fleft_q <= RESOLUTION'(1)) state_d = IDLE;
      LOAD:
        if (byte_valid_i && ld_q == LD_W'(INIT_BYTES - 1))
          state_d = LOOKUP;
      LOOKUP: state_d = EMIT;
      EMIT:
        if (symb_ready_i) state_d = RENORM;
      RENORM:
        if (!below) state_d = (cnt_q != '0) ? LOOKUP : FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o      = 1'b0;
    byte_ready_o = 1'b0;
    symb_valid_o = 1'b0;
    symb_o       = '0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    unique case (state_q)
      IDLE:   ready_o = 1'b1;
      LOAD:   byte_ready_o = 1'b1;
      RENORM: byte_ready_o = below;
      EMIT: begin
        symb_valid_o = 1'b1;
        symb_o       = slot_rd;
      end
      FINISH: begin
        done_o = 1'b1;
        err_o  = !zero_q && (x_q != LOWER_BOUND);
      end
      default: ;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    zero_d  = zero_q;
    fsym_d  = fsym_q;
    faddr_d = faddr_q;
    fleft_d = fleft_q;
    unique case (state_q)
      IDLE: begin
        if (freq_wr_i) begin
          fsym_d  = symb_i;
          faddr_d = cum_freq_i;
          fleft_d = freq_i;
        end else if (start_i) begin
          zero_d = (count_i == '0);
          if (count_i != '0) begin
            cnt_d = count_i;
            x_d   = '0;
            ld_d  = '0;
          end
        end
      end
      FILL: begin
        faddr_d = faddr_q + 1'b1;
        if (fleft_q != '0) fleft_d = fleft_q - 1'b1;
      end
      LOAD:
        if (byte_valid_i) begin
          x_d  = x_shift;
          ld_d = ld_q + 1'b1;
        end
      EMIT:
        if (symb_ready_i) begin
          x_d   = x_dec;
          cnt_d = cnt_q - 1'b1;
        end
      RENORM:
        if (below && byte_valid_i) x_d = x_shift;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      zero_q  <= 1'b0;
      fsym_q  <= '0;
      faddr_q <= '0;
      fleft_q <= '0;
    end else begin
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      zero_q  <= zero_d;
      fsym_q  <= fsym_d;
      faddr_q <= faddr_d;
      fleft_q <= fleft_d;
    end
  end

endmodule

// File: doc/rans_decoder.md
Name: rans_decoder

Overview:
- rANS entropy decoder: the inverse of the team's rANS encoder.
- Accepts the encoder byte stream presented in reverse emission order (LIFO), one byte per handshake, and emits decoded symbols in original order.
- Frequency/cumulative-frequency table is loaded through the same write port semantics as the encoder (freq_wr_i, symb_i, freq_i, cum_freq_i).
- Sits on the read-back path between the stream buffer and the symbol consumer.

Parameters:
- RESOLUTION, 10, probability resolution; M = 2^RESOLUTION slots.
- SYMBOL_WIDTH, 8, symbol and stream byte width.
- STATE_WIDTH, 24, rANS state width; must be a multiple of SYMBOL_WIDTH and greater than RESOLUTION + SYMBOL_WIDTH.
- COUNT_WIDTH, 16, width of the symbol count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- freq_wr_i  in  1  table write strobe; accepted only when ready_o=1
- symb_i  in  SYMBOL_WIDTH  symbol being written
- freq_i  in  RESOLUTION  symbol frequency
- cum_freq_i  in  RESOLUTION  symbol cumulative frequency
- start_i  in  1  begin decode; accepted only when ready_o=1
- count_i  in  COUNT_WIDTH  number of symbols to decode, sampled with start_i
- byte_valid_i  in  1  stream byte valid
- byte_i  in  SYMBOL_WIDTH  stream byte
- byte_ready_o  out  1  stream byte accepted when byte_valid_i & byte_ready_o
- symb_valid_o  out  1  decoded symbol valid
- symb_o  out  SYMBOL_WIDTH  decoded symbol
- symb_ready_i  in  1  consumer accepts symbol
- ready_o  out  1  idle; can accept a table write or start
- done_o  out  1  one-cycle pulse at end of decode
- err_o  out  1  valid with done_o; 1 means final state != LOWER_BOUND

Behaviour:
- Constants: LOWER_BOUND = 2^(STATE_WIDTH-SYMBOL_WIDTH); INIT_BYTES = STATE_WIDTH/SYMBOL_WIDTH.
- Reset: state machine goes to IDLE; ready_o=1; byte_ready_o, symb_valid_o, done_o, err_o = 0; symb_o = 0; x = 0; count = 0. Table RAM contents are not cleared. Reset mid-operation aborts immediately with no further handshakes.
- IDLE:
  - freq_wr_i=1: write freq/cum into the per-symbol table at symb_i, go to FILL.
  - else start_i=1 with count_i=0: go to FINISH; no bytes consumed; err_o=0.
  - else start_i=1: latch count, clear x, go to LOAD.
  - freq_wr_i has priority over a simultaneous start_i; start_i is dropped.
- FILL: writes slot_table[cum+i] = symb for i = 0..freq-1, one entry per cycle. Occupies max(freq,1) cycles, then returns to IDLE. ready_o=0 throughout. Strobes arriving while ready_o=0 are ignored. Slot index wraps mod M.
- LOAD: byte_ready_o=1; each accepted byte shifts in as x = (x<<SYMBOL_WIDTH) | byte (MSB first). After INIT_BYTES bytes, go to LOOKUP.
- LOOKUP (1 cycle): synchronous read of slot_table[x[RESOLUTION-1:0]] and of the freq/cum table for the returned symbol (pipelined inside the state); then go to EMIT.
- EMIT: symb_valid_o=1, symb_o = looked-up symbol; held stable while symb_ready_i=0. On handshake:
  - x = freq*(x>>RESOLUTION) + slot - cum (unsigned, STATE_WIDTH result, no overflow since freq < M);
  - count decrements;
  - go to RENORM.
- RENORM:
  - while x < LOWER_BOUND: byte_ready_o=1, one byte per cycle, x = (x<<SYMBOL_WIDTH) | byte. Never more than 2 bytes per symbol.
  - once x >= LOWER_BOUND: go to LOOKUP if count != 0, else FINISH.
  - byte_valid_i=0 stalls indefinitely.
- FINISH (1 cycle): done_o=1; err_o = (x != LOWER_BOUND), forced 0 for the count=0 case; then IDLE.
- byte_ready_o is 0 outside LOAD and RENORM.
- Symbol latency: from the last LOAD byte, symb_valid_o rises 2 cycles later.

Decomposition:
- rans_pkg holds:
  - state enum (IDLE, FILL, LOAD, LOOKUP, EMIT, RENORM, FINISH);
  - LOWER_BOUND and INIT_BYTES as functions of the parameters;
  - freq/cum entry struct.
- Sub-module rans_slot_ram: single-clock RAM, one write port and one registered-read port, depth and width parameterised. Instantiated for the slot table (M x SYMBOL_WIDTH) and the freq/cum table (2^SYMBOL_WIDTH x 2*RESOLUTION).

Test Plan:
- Table fill: write symbol 0x41 freq 1020 cum 0 -> ready_o low exactly 1020 cycles; then write 0x43 freq 4 cum 1020 -> ready_o low 4 cycles. A freq 0 write holds ready_o low 1 cycle and writes no slot entries.
- Clean decode: start with count 1, bytes 0x01,0x03,0xFC,0x00 -> symb_o=0x43; exactly one RENORM byte consumed; done_o pulse with err_o=0 (final x=0x010000).
- Error detect: same table, count 1, bytes 0x01,0x00,0x00,0x00 -> symb_o=0x41; x'=65280 so one RENORM byte consumed; done_o with err_o=1 (final x=0xFF0000).
- Backpressure: symb_ready_i low 5 cycles in EMIT -> symb_valid_o held, symb_o stable, byte_ready_o=0, x unchanged.
- Collisions: freq_wr_i and start_i together in IDLE -> table write wins, no decode. start_i with count 0 -> done_o next cycle, err_o=0, no bytes consumed.
- Reset mid-RENORM -> next cycle in IDLE with ready_o=1, all other outputs 0; a subsequent clean decode still passes using the retained table.
